led_panel_rx: RTL

Synthesizable receiver for the LED panel serial interface produced by `led_display_driver` / `led_display_driver_phy`. It samples the bit clock, RGB, latch, output-enable and row-address lines with the system clock, captures one row of top/bottom pixel bits, and replays each latched row as a column-indexed valid/ready stream. It is used in-system for loopback self-test and in benches as a checkable replacement for the behavioural panel model.

---
 rtl/led_panel_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 32 +++
 rtl/led_panel_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/led_panel_pkg.sv
// Shared types for the LED panel receiver.
// Stream FSM states, pixel type and OE counter width.
package led_panel_pkg;

  typedef enum logic {
    RX_IDLE,
    RX_STREAM
  } rx_state_e;

  typedef logic [2:0] rgb_t;

  localparam int OE_CNT_W = 16;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a third stage for rise detection.
// q_o is the settled level; rise_o flags a 0->1 transition on it.
module sync_edge_det #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;
  logic [W-1:0] s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/led_panel_rx.sv
// LED panel serial receiver: captures one row of top/bottom pixels
// per latch and replays it as a column-indexed valid/ready stream.
import led_panel_pkg::*;

module led_panel_rx #(
  parameter int NUM_COLS      = 64,
  parameter int ADDR_BITS     = 3,
  parameter bit OE_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk_in,
  input  logic                        reset_in,
  input  logic                        bit_clk_in,
  input  logic [2:0]                  rgb_top_in,
  input  logic [2:0]                  rgb_bot_in,
  input  logic                        latch_enable_in,
  input  logic                        output_enable_in,
  input  logic [ADDR_BITS-1:0]        addr_in,
  output logic                        row_valid_out,
  input  logic                        row_ready_in,
  output logic [ADDR_BITS-1:0]        row_addr_out,
  output logic [$clog2(NUM_COLS)-1:0] col_out,
  output logic [2:0]                  rgb_top_out,
  output logic [2:0]                  rgb_bot_out,
  output logic                        row_done_out,
  output logic [15:0]                 oe_cycles_out,
  output logic                        overflow_out,
  output logic                        underrun_out,
  output logic                        overrun_out,
  input  logic                        clear_flags_in
);

  localparam int COLW = $clog2(NUM_COLS);
  localparam int CNTW = $clog2(NUM_COLS + 1);
  localparam int DW   = 6 + ADDR_BITS;
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(NUM_COLS);
  localparam logic [COLW-1:0] COL_LAST = COLW'(NUM_COLS - 1);

  logic [2:0]    ctl_s;
  logic [2:0]    ctl_r;
  logic [DW-1:0] dat_s;
  logic [DW-1:0] dat_rise_unused;

  sync_edge_det #(.W(3)) u_sync_ctl (
    .clk_i  (clk_in),
    .rst_i  (reset_in),
    .d_i    ({output_enable_in, latch_enable_in, bit_clk_in}),
    .q_o    (ctl_s),
    .rise_o (ctl_r)
  );

  sync_edge_det #(.W(DW)) u_sync_dat (
    .clk_i  (clk_in),
    .rst_i  (reset_in),
    .d_i    ({addr_in, rgb_bot_in, rgb_top_in}),
    .q_o    (dat_s),
    .rise_o (dat_rise_unused)
  );

  logic                 bit_rise;
  logic                 le_rise;
  logic                 oe_act;
  rgb_t                 d_top;
  rgb_t                 d_bot;
  logic [ADDR_BITS-1:0] d_addr;

  assign bit_rise = ctl_r[0];
  assign le_rise  = ctl_r[1];
  assign oe_act   = OE_ACTIVE_LOW ? ~ctl_s[2] : ctl_s[2];
  assign d_top    = dat_s[2:0];
  assign d_bot    = dat_s[5:3];
  assign d_addr   = dat_s[6 +: ADDR_BITS];

  rx_state_e             state_q, state_d;
  logic [CNTW-1:0]       cnt_q;
  logic [NUM_COLS-1:0]   cap_mask_q;
  rgb_t                  cap_top_q [NUM_COLS];
  rgb_t                  cap_bot_q [NUM_COLS];
  logic [OE_CNT_W-1:0]   oe_cnt_q;

  logic                  bit_wr;
  logic [COLW-1:0]       wr_idx;
  logic [CNTW-1:0]       cnt_post;
  logic [NUM_COLS-1:0]   mask_post;
  logic                  load;

  assign bit_wr    = bit_rise && (cnt_q != CNT_FULL);
  assign wr_idx    = cnt_q[COLW-1:0];
  assign cnt_post  = cnt_q + CNTW'(bit_wr);
  assign mask_post = cap_mask_q
                   | ({{(NUM_COLS-1){1'b0}}, bit_wr} << wr_idx);
  assign load      = le_rise && (state_q == RX_IDLE);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cnt_q      <= '0;
      cap_mask_q <= '0;
      oe_cnt_q   <= '0;
    end else if (le_rise) begin
      cnt_q      <= '0;
      cap_mask_q <= '0;
      oe_cnt_q   <= '0;
    end else begin
      cnt_q      <= cnt_post;
      cap_mask_q <= mask_post;
      if (oe_act && (oe_cnt_q != '1)) oe_cnt_q <= oe_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (bit_wr) begin
      cap_top_q[wr_idx] <= d_top;
      cap_bot_q[wr_idx] <= d_bot;
    end
  end

  // A bit landing in the latch cycle is folded into the copied row.
  rgb_t                 str_top_q [NUM_COLS];
  rgb_t                 str_bot_q [NUM_COLS];
  logic [NUM_COLS-1:0]  str_mask_q;
  logic [ADDR_BITS-1:0] row_addr_q;
  logic [OE_CNT_W-1:0]  oe_cycles_q;

  always_ff @(posedge clk_in) begin
    if (load) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        str_top_q[i] <= (bit_wr && wr_idx == COLW'(i)) ? d_top : cap_top_q[i];
        str_bot_q[i] <= (bit_wr && wr_idx == COLW'(i)) ? d_bot : cap_bot_q[i];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      str_mask_q  <= '0;
      row_addr_q  <= '0;
      oe_cycles_q <= '0;
    end else if (load) begin
      str_mask_q  <= mask_post;
      row_addr_q  <= d_addr;
      oe_cycles_q <= oe_cnt_q;
    end
  end

  logic [COLW-1:0] col_q, col_d;
  logic            done_q, done_d;
  logic            valid;
  logic            fire;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= RX_IDLE;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    done_d  = 1'b0;
    valid   = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (load) begin
          state_d = RX_STREAM;
          col_d   = '0;
        end
      end
      RX_STREAM: begin
        valid = 1'b1;
        fire  = row_ready_in;
        if (fire) begin
          if (col_q == COL_LAST) begin
            state_d = RX_IDLE;
            col_d   = '0;
            done_d  = 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  logic ovf_q, und_q, ovr_q;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      ovf_q <= 1'b0;
      und_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~clear_flags_in) | (bit_rise && cnt_q == CNT_FULL);
      und_q <= (und_q & ~clear_flags_in) | (le_rise && cnt_post != CNT_FULL);
      ovr_q <= (ovr_q & ~clear_flags_in) | (le_rise && state_q != RX_IDLE);
    end
  end

  assign row_valid_out = valid;
  assign row_addr_out  = row_addr_q;
  assign col_out       = col_q;
  assign rgb_top_out   = str_mask_q[col_q] ? str_top_q[col_q] : 3'b000;
  assign rgb_bot_out   = str_mask_q[col_q] ? str_bot_q[col_q] : 3'b000;
  assign row_done_out  = done_q;
  assign oe_cycles_out = oe_cycles_q;
  assign overflow_out  = ovf_q;
  assign underrun_out  = und_q;
  assign overrun_out   = ovr_q;

endmodule
